// File: rtl/cv32e40p_obi_resp_pkg.sv
// Shared types and constants for the OBI memory responder: grant FSM states,
// response pipe entry and parameter range limits.
package cv32e40p_obi_resp_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } obi_gnt_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } obi_resp_t;

  localparam int unsigned RESP_W         = $bits(obi_resp_t);
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned GNT_WAIT_MAX   = 15;
  localparam int unsigned RVALID_LAT_MIN = 1;
  localparam int unsigned RVALID_LAT_MAX = 8;
  localparam int unsigned MAX_OUT_MIN    = 1;

  // Even parity: bit b makes byte b plus its parity bit hold an even number of ones.
  function automatic logic [3:0] byte_parity(input logic [31:0] w);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// Fixed-latency response shift register; the last stage feeds the OBI response
// outputs. Asynchronous clear drops every in-flight response.
module cv32e40p_obi_resp_pipe
  import cv32e40p_obi_resp_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [RESP_W-1:0] in_i,
  output logic [RESP_W-1:0] out_o
);

  obi_resp_t stage_q [LAT];
  obi_resp_t stage_d [LAT];

  always_comb begin
    stage_d[0] = obi_resp_t'(in_i);
    for (int i = 1; i < LAT; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign out_o = stage_q[LAT-1];

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI data-memory responder with grant wait states, fixed response latency and an
// outstanding limit. Define CV32E40P_OBI_RESP_PARITY_EN for per-byte parity and error injection.
//
// state  | meaning
// S_IDLE | no request being delayed; counts as the first wait cycle of a new request
// S_WAIT | request held, cnt_q wait cycles still to go before gnt_o may assert
module cv32e40p_obi_mem_responder
  import cv32e40p_obi_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 14,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RVALID_LAT      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  input  logic        inject_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic PARAM_OK = (GNT_WAIT <= GNT_WAIT_MAX)
                           && (RVALID_LAT >= RVALID_LAT_MIN) && (RVALID_LAT <= RVALID_LAT_MAX)
                           && (MAX_OUTSTANDING >= MAX_OUT_MIN) && (MAX_OUTSTANDING <= RVALID_LAT + 1);

  obi_gnt_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      out_q, out_d;
  logic                  wait_done, slot_free, gnt;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [31:0]           mem_q [DEPTH];
  obi_resp_t             resp_in, resp_out;
  logic                  unused_in;

  assign word_addr = addr_i[ADDR_WIDTH+1:2];
  assign slot_free = (out_q < CNT_W'(MAX_OUTSTANDING));
  assign unused_in = ^{addr_i, inject_i};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (GNT_WAIT == 0) begin
          wait_done = 1'b1;
        end else if (req_i) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(GNT_WAIT) - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!req_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          wait_done = 1'b1;
          if (slot_free) state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gated by reset so no grant (and no array write) can leak out while in reset.
  assign gnt   = req_i & wait_done & slot_free & rst_ni;
  assign gnt_o = gnt;

  // A retirement this cycle only frees its slot from the next cycle on.
  assign out_d = out_q + CNT_W'(gnt) - CNT_W'(resp_out.valid);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

`ifdef CV32E40P_OBI_RESP_PARITY_EN
  logic [3:0] par_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (gnt && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[word_addr][8*b +: 8] <= wdata_i[8*b +: 8];
          par_q[word_addr][b]        <= (^wdata_i[8*b +: 8]) ^ (inject_i && (b == 0));
        end
      end
    end
  end

  always_comb begin
    resp_in = '0;
    if (gnt) begin
      resp_in.valid = 1'b1;
      if (!we_i) begin
        resp_in.rdata = mem_q[word_addr];
        resp_in.err   = |(par_q[word_addr] ^ byte_parity(mem_q[word_addr]));
      end
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (gnt && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[word_addr][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_comb begin
    resp_in = '0;
    if (gnt) begin
      resp_in.valid = 1'b1;
      if (!we_i) resp_in.rdata = mem_q[word_addr];
    end
  end
`endif

  cv32e40p_obi_resp_pipe #(
    .LAT (RVALID_LAT)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .in_i   (resp_in),
    .out_o  (resp_out)
  );

  assign rvalid_o = resp_out.valid;
  assign rdata_o  = resp_out.rdata;
  assign err_o    = resp_out.err;

  a_params_ok : assert property (@(posedge clk_i) PARAM_OK);
  a_out_sat   : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 out_q <= CNT_W'(MAX_OUTSTANDING));

endmodule
